addr_decode_router: RTL
=======================

Name: addr_decode_router

Overview:
- Single-input, multi-output address router for the AXI interconnect; the 1->N counterpart of the N->1 arbiter.
- Accepts one address-channel request (addr, id) per transaction.
- Decodes the target port from a per-port base/aperture map and forwards the request to exactly one master port.
- Tracks outstanding transactions so routing to a new target never reorders completions.
- Requests to unmapped addresses get a local decode-error response.

Parameters:
M_COUNT, 4, number of downstream master ports
ADDR_WIDTH, 32, address width
ID_WIDTH, 8, transaction ID width
M_BASE_ADDR, 0, packed M_COUNT*ADDR_WIDTH base addresses, port i at slice i
M_ADDR_WIDTH, {M_COUNT{32'd16}}, packed M_COUNT*32 aperture widths in bits; 0 disables the port
MAX_OUTSTANDING, 8, max in-flight transactions to the current target

Ports:
clk  input  1  clock
reset  input  1  asynchronous reset, active-high
s_addr  input  ADDR_WIDTH  request address
s_id  input  ID_WIDTH  request ID
s_valid  input  1  request valid
s_ready  output  1  request accepted when s_valid && s_ready
m_addr  output  ADDR_WIDTH  forwarded address, common to all ports
m_id  output  ID_WIDTH  forwarded ID, common to all ports
m_valid  output  M_COUNT  one-hot forward valid
m_ready  input  M_COUNT  per-port ready
m_cpl  input  M_COUNT  one-cycle pulse per completed transaction on port i
err_valid  output  1  decode-error response valid
err_id  output  ID_WIDTH  ID of the failed request
err_ready  input  1  error response accepted
busy  output  1  outstanding count nonzero or state != IDLE

Behaviour:
- Reset (asynchronous, active-high):
  - state=IDLE, count=0, last_tgt=0.
  - m_valid=0, err_valid=0, m_addr/m_id/err_id=0.
  - s_ready held 0 while reset is asserted.
- Decode:
  - Port i matches when M_ADDR_WIDTH[i]!=0 and (s_addr>>M_ADDR_WIDTH[i])==(M_BASE_ADDR[i]>>M_ADDR_WIDTH[i]).
  - The lowest-index match wins.
  - No match gives tgt=ERR, an internal index distinct from every port.
- Dispatch condition `ok`:
  - Port target: count==0, or (tgt==last_tgt and count<MAX_OUTSTANDING).
  - ERR target: count==0.
- States:
  - IDLE: s_ready=1. On accept, register addr, id and tgt. Go to FWD (port, ok), ERR (ERR target, ok) or HOLD (not ok).
  - HOLD: s_ready=0. Re-evaluate ok on the registered tgt every cycle; go to FWD or ERR when it holds.
  - FWD: m_valid[tgt]=1 and all other bits 0. m_addr/m_id are stable until m_ready[tgt]. On handshake: count++, last_tgt<=tgt, go to IDLE.
  - ERR: err_valid=1, err_id=registered id. Held until err_ready, then go to IDLE. Count is unchanged.
- Latency and throughput:
  - Accept in cycle N gives the earliest m_valid/err_valid in cycle N+1.
  - Maximum throughput is one request per 2 cycles.
  - Once asserted, valid never drops without a handshake (AXI rule).
- Counter:
  - Width is clog2(MAX_OUTSTANDING+1).
  - Decrements on m_cpl[last_tgt] when count>0.
  - m_cpl on any other port, or with count==0, is ignored; no underflow.
  - FWD handshake and decrement in the same cycle leave count unchanged.
- Boundaries:
  - At count==MAX_OUTSTANDING, a same-target request waits in HOLD until a completion arrives.
  - A target switch waits until count drains to 0.
  - last_tgt persists after count reaches 0; it has no effect then.
- Reset mid-transaction: all state is discarded immediately and no further valid is asserted. Upstream and downstream are reset together.

Test Plan:
Setup: M_COUNT=2, port0 base 0x0000_0000 width 16, port1 base 0x0001_0000 width 16, MAX_OUTSTANDING=2.
1. s_addr=0x0000_1234 id=0x05, m_ready=2'b01 -> m_valid=2'b01 one cycle after accept, m_addr=0x0000_1234, m_id=0x05, count=1.
2. Three back-to-back requests to 0x0000_0010, m_ready=1, no m_cpl -> first two forward, count=2. Third holds in HOLD (s_ready=0, m_valid=0) until m_cpl[0] pulses, then forwards the next cycle; count stays 2.
3. One outstanding to port0, then request 0x0001_0000 -> HOLD until m_cpl[0], then m_valid=2'b10, last_tgt=1, count=1.
4. s_addr=0x0005_0000 id=0x3A with count=0 -> err_valid=1, err_id=0x3A, m_valid=0. With err_ready held 0 for 3 cycles, err_valid stays 1. After err_ready=1, state returns to IDLE and count=0.
5. FWD to port0 with m_ready=1 and m_cpl[0]=1 in the same cycle while count=1 -> count stays 1. A stray m_cpl[1] pulse leaves count unchanged.
6. Assert reset while in FWD with m_valid=2'b01 -> m_valid=0, count=0 and s_ready=0 immediately. After release, s_ready=1 the next cycle.

Source files
------------

// File: rtl/addr_decode_router.sv
// addr_decode_router: 1->N address-channel router.
// Decodes each request against a per-port base/aperture map and forwards it to
// exactly one master port. Completions are never reordered: the router only
// switches to a new target once every transaction to the previous target has
// completed. Unmapped addresses are answered locally with a decode error.
//
// Handshake semantics (all channels): a transfer happens on a rising clock edge
// where valid && ready are both high. Once valid is raised it stays high, with
// its payload stable, until that transfer happens. Ready may depend on valid.
module addr_decode_router #(
    parameter int M_COUNT = 4,
    parameter int ADDR_WIDTH = 32,
    parameter int ID_WIDTH = 8,
    parameter logic [M_COUNT*ADDR_WIDTH-1:0] M_BASE_ADDR = '0,
    parameter logic [M_COUNT*32-1:0] M_ADDR_WIDTH = {M_COUNT{32'd16}},
    parameter int MAX_OUTSTANDING = 8,
    localparam int TGT_W = $clog2(M_COUNT + 1),
    localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] s_addr,
    input  logic [ID_WIDTH-1:0]   s_id,
    input  logic                  s_valid,
    output logic                  s_ready,
    output logic [ADDR_WIDTH-1:0] m_addr,
    output logic [ID_WIDTH-1:0]   m_id,
    output logic [M_COUNT-1:0]    m_valid,
    input  logic [M_COUNT-1:0]    m_ready,
    input  logic [M_COUNT-1:0]    m_cpl,
    output logic                  err_valid,
    output logic [ID_WIDTH-1:0]   err_id,
    input  logic                  err_ready,
    output logic                  busy,
    output logic [1:0]            dbg_state,
    output logic [CNT_W-1:0]      dbg_count,
    output logic [TGT_W-1:0]      dbg_last_tgt
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HOLD = 2'd1,
        ST_FWD  = 2'd2,
        ST_ERR  = 2'd3
    } state_t;

    // Internal target index for "no port matched"; never a valid port number.
    localparam logic [TGT_W-1:0] TGT_ERR = TGT_W'(M_COUNT);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_OUTSTANDING);

    state_t                state;
    state_t                next_state;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [ID_WIDTH-1:0]   id_q;
    logic [TGT_W-1:0]      tgt_q;
    logic [TGT_W-1:0]      last_tgt;
    logic [CNT_W-1:0]      count;

    logic [TGT_W-1:0]      dec_tgt;
    logic                  ok_dec;
    logic                  ok_reg;
    logic                  load;
    logic                  idle_ready;
    logic                  fwd_hs;
    logic                  cnt_inc;
    logic                  cnt_dec;

    // Address decode: scan high to low so the lowest-index match wins.
    always_comb begin
        dec_tgt = TGT_ERR;
        for (int i = M_COUNT - 1; i >= 0; i--) begin
            if ((M_ADDR_WIDTH[i*32 +: 32] != 32'd0) &&
                ((s_addr >> M_ADDR_WIDTH[i*32 +: 32]) ==
                 (M_BASE_ADDR[i*ADDR_WIDTH +: ADDR_WIDTH] >> M_ADDR_WIDTH[i*32 +: 32]))) begin
                dec_tgt = TGT_W'(i);
            end
        end
    end

    // Dispatch is allowed with nothing in flight, or when staying on the same
    // port with room left. The error target never piggybacks on in-flight work,
    // so a local error response cannot overtake a downstream completion.
    assign ok_dec = (count == '0) ||
                    ((dec_tgt != TGT_ERR) && (dec_tgt == last_tgt) && (count < CNT_MAX));
    assign ok_reg = (count == '0) ||
                    ((tgt_q != TGT_ERR) && (tgt_q == last_tgt) && (count < CNT_MAX));

    // One-hot forward valid, driven purely from state so reset clears it at once.
    always_comb begin
        m_valid = '0;
        for (int i = 0; i < M_COUNT; i++) begin
            m_valid[i] = (state == ST_FWD) && (tgt_q == TGT_W'(i));
        end
    end

    assign fwd_hs = (state == ST_FWD) && ((m_valid & m_ready) != '0);

    // FSM next-state and upstream ready.
    always_comb begin
        next_state = state;
        idle_ready = 1'b0;
        load       = 1'b0;
        case (state)
            ST_IDLE: begin
                idle_ready = 1'b1;
                if (s_valid) begin
                    load = 1'b1;
                    if (!ok_dec) begin
                        next_state = ST_HOLD;
                    end else if (dec_tgt == TGT_ERR) begin
                        next_state = ST_ERR;
                    end else begin
                        next_state = ST_FWD;
                    end
                end
            end
            ST_HOLD: begin
                if (ok_reg) begin
                    next_state = (tgt_q == TGT_ERR) ? ST_ERR : ST_FWD;
                end
            end
            ST_FWD: begin
                if (fwd_hs) begin
                    next_state = ST_IDLE;
                end
            end
            ST_ERR: begin
                if (err_ready) begin
                    next_state = ST_IDLE;
                end
            end
            default: next_state = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Request capture on accept; payload then stays stable through FWD/ERR.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            addr_q <= '0;
            id_q   <= '0;
            tgt_q  <= '0;
        end else if (load) begin
            addr_q <= s_addr;
            id_q   <= s_id;
            tgt_q  <= dec_tgt;
        end
    end

    // Completions only count on the port currently owning the in-flight work.
    always_comb begin
        cnt_dec = 1'b0;
        for (int i = 0; i < M_COUNT; i++) begin
            if ((last_tgt == TGT_W'(i)) && m_cpl[i]) begin
                cnt_dec = 1'b1;
            end
        end
        if (count == '0) begin
            cnt_dec = 1'b0;
        end
    end

    assign cnt_inc = fwd_hs;

    // Outstanding counter and owning target.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count    <= '0;
            last_tgt <= '0;
        end else begin
            if (cnt_inc && !cnt_dec) begin
                count <= count + 1'b1;
            end else if (!cnt_inc && cnt_dec) begin
                count <= count - 1'b1;
            end
            if (fwd_hs) begin
                last_tgt <= tgt_q;
            end
        end
    end

    assign s_ready      = idle_ready && !reset;
    assign m_addr       = addr_q;
    assign m_id         = id_q;
    assign err_valid    = (state == ST_ERR);
    assign err_id       = id_q;
    assign busy         = (count != '0) || (state != ST_IDLE);
    assign dbg_state    = state;
    assign dbg_count    = count;
    assign dbg_last_tgt = last_tgt;

endmodule
